sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock first-in/first-out buffer between one producer and one consumer in the same clock domain.
//  Stores up to DEPTH words of DATA_WIDTH bits and presents registered read data.
//  Provides full/empty status for producer/consumer flow control.
// PARAMETERS
//  DATA_WIDTH  8  width of each stored word in bits (>=1)
//  DEPTH       8  number of storage entries; must be a power of 2, >=2
// PORTS
//  clk       in   1           clock; all logic on the rising edge
//  rst       in   1           reset: synchronous, active-high
//  w_en      in   1           write request; data_in is pushed when accepted
//  r_en      in   1           read request; the head word is popped when accepted
//  data_in   in   DATA_WIDTH  write data, sampled on an accepted write
//  data_out  out  DATA_WIDTH  registered read data
//  full      out  1           high when DEPTH words are stored
//  empty     out  1           high when 0 words are stored
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0. rst has priority over w_en/r_en in the same cycle.
//  - Reset mid-operation discards all stored contents. The storage array itself is not cleared.
//  - Pointers are $clog2(DEPTH)+1 bits wide; the extra MSB is a wrap bit.
//    empty = (wr_ptr == rd_ptr).
//    full  = (lower bits equal) && (wrap bits differ).
//  - Flags are combinational from the registered pointers, so they are valid in the cycle after the pointer update.
//  - Write accepted iff w_en && !full: mem[wr_ptr] <= data_in, then wr_ptr increments.
//    A write while full is dropped silently; pointers and contents are unchanged.
//  - Read accepted iff r_en && !empty: data_out <= mem[rd_ptr], then rd_ptr increments.
//    The data is visible one cycle after the r_en edge (latency 1).
//    A read while empty is ignored; data_out holds its value.
//  - data_out holds its last value whenever no read is accepted.
//  - Simultaneous w_en && r_en: each is qualified against the flags of the current cycle.
//      not full and not empty: both occur; occupancy is unchanged.
//      empty: only the write occurs (no read-through; the data appears on a later read).
//      full: only the read occurs; the write is dropped.
//  - Pointers wrap modulo 2*DEPTH naturally. Order is strictly FIFO across the wrap.
// CONFIGURATION
//  Macro SYNC_FIFO_STATUS_EN.
//  Defined: adds these output ports.
//    count         out  $clog2(DEPTH)+1  number of stored words = wr_ptr - rd_ptr
//    almost_full   out  1                high when count >= DEPTH-1
//    almost_empty  out  1                high when count <= 1
//    All are combinational from the pointers.
//    Reset values: count=0, almost_full=0, almost_empty=1.
//  Undefined: these ports and their logic are absent. Core behaviour is identical.
// STRUCTURE
//  Package sync_fifo_pkg: DEFAULT_DATA_WIDTH=8, DEFAULT_DEPTH=8, and the function ptr_w(depth)=$clog2(depth)+1.
//  Sub-module sync_fifo_mem: DEPTH x DATA_WIDTH register array.
//    Synchronous write port (we, waddr, wdata) and a combinational read address port.
//    sync_fifo instantiates it and owns the pointers, flags and the data_out register.
//  Elaboration-time assertion that DEPTH is a power of 2.
// TESTING
//  1. Reset: hold rst=1 for 2 cycles -> empty=1, full=0, data_out=0. r_en=1 with no writes -> data_out stays 0.
//  2. Fill/drain: write 0x01..0x08 -> full=1 after the 8th write. Then read 8 times -> data_out=0x01..0x08 in order, each 1 cycle after its r_en; empty=1 after the last read.
//  3. Overflow: when full, write 0xAA -> dropped. The subsequent 8 reads return 0x01..0x08; 0xAA is never seen.
//  4. Simultaneous: with 3 words stored, w_en=r_en=1 for 5 cycles -> occupancy stays 3, data order preserved across pointer wrap.
//     With the FIFO empty, w_en=r_en=1 -> only the write occurs; empty deasserts the next cycle.
//  5. Mid-operation reset: store 5 words, pulse rst for 1 cycle -> empty=1 and data_out=0. A new write of 0x55 followed by a read returns 0x55.
//  6. SYNC_FIFO_STATUS_EN defined: count tracks 0->8->0 during scenario 2.
//     almost_full=1 when count is 7 and 8; almost_empty=1 when count is 0 and 1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for the sync_fifo block.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with a synchronous write port and an
// asynchronous (combinational) read port.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define SYNC_FIFO_STATUS_EN to add count/almost_full/almost_empty outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty
`ifdef SYNC_FIFO_STATUS_EN
    ,
    output logic [ptr_w(DEPTH)-1:0] count,
    output logic                    almost_full,
    output logic                    almost_empty
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered pointers; the wrap bit
    // distinguishes full from empty when the address bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign wr_acc = w_en && !full && !rst;
    assign rd_acc = r_en && !empty && !rst;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                data_out <= rd_data;
                rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_STATUS_EN
    // Modular subtraction gives occupancy directly across pointer wrap.
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= PW'(DEPTH - 1));
    assign almost_empty = (count <= PW'(1));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int DW    = DEFAULT_DATA_WIDTH;
    localparam int DEPTH = DEFAULT_DEPTH;
    localparam int PW    = ptr_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_STATUS_EN
    logic [PW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty)
`ifdef SYNC_FIFO_STATUS_EN
        ,
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents of the FIFO, and data expected on data_out.
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] exp_q[$];
    bit            rd_evt  = 1'b0;
    bit            rst_evt = 1'b0;
    bit            chk_on  = 1'b0;
    logic [DW-1:0] last_out = '0;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model is updated right after the sampling edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit wr_acc, rd_acc;
        w_en = w; r_en = r; data_in = d; rst = rs;
        @(posedge clk);
        if (rs) begin
            mdl.delete();
            exp_q.delete();
            rd_evt  = 1'b0;
            rst_evt = 1'b1;
        end else begin
            wr_acc = w && (mdl.size() < DEPTH);
            rd_acc = r && (mdl.size() > 0);
            rst_evt = 1'b0;
            rd_evt  = rd_acc;
            if (rd_acc) exp_q.push_back(mdl.pop_front());
            if (wr_acc) mdl.push_back(d);
        end
        chk_on = 1'b1;
        #1;
    endtask

    // Monitor: compares DUT outputs to the model mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            if (rst_evt) begin
                last_out = '0;
            end else if (rd_evt) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got read event expected queued data at %0t", $time);
                end else begin
                    last_out = exp_q.pop_front();
                end
            end
            check("data_out", 32'(data_out), 32'(last_out));
            check("empty", 32'(empty), 32'(mdl.size() == 0));
            check("full", 32'(full), 32'(mdl.size() == DEPTH));
`ifdef SYNC_FIFO_STATUS_EN
            check("count", 32'(count), 32'(mdl.size()));
            check("almost_full", 32'(almost_full), 32'(mdl.size() >= DEPTH - 1));
            check("almost_empty", 32'(almost_empty), 32'(mdl.size() <= 1));
`endif
        end
    end

    initial begin
        // Reset held two cycles, then reads on an empty FIFO
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);

        // Fill 0x01..0x08, attempt overflow with 0xAA, drain
        for (int i = 1; i <= DEPTH; i++) step(1, 0, DW'(i), 0);
        step(1, 0, 8'hAA, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Three stored, then five cycles of simultaneous write/read across wrap
        for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h10 + i), 0);
        for (int i = 0; i < 5; i++) step(1, 1, DW'(8'h20 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        // Simultaneous on empty: only the write lands
        step(1, 1, 8'h77, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Full plus simultaneous: only the read lands
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h30 + i), 0);
        step(1, 1, 8'hEE, 0);
        step(0, 0, 8'h00, 0);

        // Mid-operation reset
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, DW'(8'h40 + i), 0);
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h55, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Random traffic with shifting write/read bias
        for (int i = 0; i < 600; i++) begin
            int wb;
            wb = (i / 100) % 2 == 0 ? 70 : 30;
            step(($urandom_range(99) < wb), ($urandom_range(99) < 100 - wb),
                 DW'($urandom), ($urandom_range(199) == 0));
        end

        for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
